// File: rtl/gat_pkg.sv
// Shared definitions for the GAT BRAM loader.
//   load_state_e : loader FSM state, encoding is visible on state_o
//   ch_w()       : channel-select width for a given channel count
//   len_w()      : per-channel word-count width for a given address width
package gat_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } load_state_e;

    localparam int unsigned StateW = 2;

    // A single channel still needs a 1-bit select so the port stays legal.
    function automatic int unsigned ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // One extra bit so a full address space of words can be counted.
    function automatic int unsigned len_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/gat_bram_loader_if.sv
// Host-to-BRAM load bus.
//   host_ch/host_din/host_ena/host_wea/host_addra : host byte-addressed write port
//   bram_din/bram_addra/bram_ena/bram_wea         : registered per-channel BRAM write port
// master = host side, slave = loader side.
interface gat_bram_loader_if #(
    parameter int unsigned TOP_WIDTH = 32,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 19,
    parameter int unsigned ADDR_W    = 18
);

    localparam int unsigned CH_W = gat_pkg::ch_w(NUM_CH);

    logic [CH_W-1:0]      host_ch;
    logic [TOP_WIDTH-1:0] host_din;
    logic                 host_ena;
    logic                 host_wea;
    logic [ADDR_W+1:0]    host_addra;

    logic [DATA_W-1:0]    bram_din;
    logic [ADDR_W-1:0]    bram_addra;
    logic [NUM_CH-1:0]    bram_ena;
    logic [NUM_CH-1:0]    bram_wea;

    modport master (
        output host_ch, host_din, host_ena, host_wea, host_addra,
        input  bram_din, bram_addra, bram_ena, bram_wea
    );

    modport slave (
        input  host_ch, host_din, host_ena, host_wea, host_addra,
        output bram_din, bram_addra, bram_ena, bram_wea
    );

endinterface

// File: rtl/gat_load_ch_counter.sv
// Per-channel word counter for the BRAM loader.
//   start_i   : accepted load_start; clears count/flags and latches cfg_len_i
//   abort_i   : clears count and done, keeps the overflow flag
//   wr_i      : aligned write in LOAD addressed to this channel
//   accept_o  : write is taken (channel not yet full)
//   done_o    : expected word count reached (registered)
//   ovf_o     : sticky, a write arrived after done
module gat_load_ch_counter #(
    parameter int unsigned LEN_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             wr_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    output logic             accept_o,
    output logic             done_o,
    output logic             ovf_o
);

    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    assign accept_o = wr_i & ~done_q;
    assign done_o   = done_q;
    assign ovf_o    = ovf_q;

    always_comb begin
        cnt_d  = cnt_q;
        len_d  = len_q;
        done_d = done_q;
        ovf_d  = ovf_q;
        if (abort_i) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (start_i) begin
            cnt_d  = '0;
            len_d  = cfg_len_i;
            done_d = (cfg_len_i == '0);
            ovf_d  = 1'b0;
        end else begin
            if (accept_o) begin
                cnt_d = cnt_q + LEN_W'(1);
                // Done lands on the same edge as the last strobe.
                if (cnt_d == len_q) begin
                    done_d = 1'b1;
                end
            end
            if (wr_i && done_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: rtl/gat_bram_loader.sv
// Host-driven loader that scatters words into NUM_CH target BRAMs and tracks
// per-channel completion against programmed lengths.
//   clk, rst_n             : clock, async active-low reset
//   load_start, load_abort : session arm / abandon pulses (abort wins)
//   cfg_len                : per-channel expected word counts, ch0 in the LSBs
//   bus_io (slave)         : host write port in, registered BRAM strobes out
//   load_done, all_done    : per-channel and global completion
//   err_align, err_ovf     : sticky misaligned / overflow errors per channel
//   state_o                : FSM state (IDLE=0, LOAD=1, DONE=2)
module gat_bram_loader
    import gat_pkg::*;
#(
    parameter int unsigned TOP_WIDTH = 32,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 19,
    parameter int unsigned ADDR_W    = 18
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic                         load_abort,
    input  logic [NUM_CH*(ADDR_W+1)-1:0] cfg_len,
    gat_bram_loader_if.slave             bus_io,
    output logic [NUM_CH-1:0]            load_done,
    output logic                         all_done,
    output logic [NUM_CH-1:0]            err_align,
    output logic [NUM_CH-1:0]            err_ovf,
    output logic [StateW-1:0]            state_o
);

    localparam int unsigned CH_W  = ch_w(NUM_CH);
    localparam int unsigned LEN_W = len_w(ADDR_W);

    load_state_e       state_q, state_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_CH-1:0] ena_q, ena_d;
    logic [NUM_CH-1:0] err_align_q, err_align_d;

    logic              start_acc;
    logic              wr_req;
    logic              ch_ok;
    logic              aligned;
    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] accept;
    logic              unused_din;

    // Only the low DATA_W bits of the host word reach the BRAMs.
    assign unused_din = ^bus_io.host_din;

    // A start in LOAD is ignored; abort always takes priority.
    assign start_acc = load_start & ~load_abort & (state_q != StLoad);
    assign wr_req    = (state_q == StLoad) & bus_io.host_ena & bus_io.host_wea;
    assign ch_ok     = int'(bus_io.host_ch) < int'(NUM_CH);
    assign aligned   = (bus_io.host_addra[1:0] == 2'b00);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_sel[g] = (bus_io.host_ch == CH_W'(g));
        assign ch_wr[g]  = wr_req & ch_ok & aligned & ch_sel[g];

        gat_load_ch_counter #(
            .LEN_W (LEN_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .start_i   (start_acc),
            .abort_i   (load_abort),
            .wr_i      (ch_wr[g]),
            .cfg_len_i (cfg_len[g*LEN_W +: LEN_W]),
            .accept_o  (accept[g]),
            .done_o    (load_done[g]),
            .ovf_o     (err_ovf[g])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_acc) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (&load_done) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load_abort) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        ena_d       = accept;
        din_d       = din_q;
        addr_d      = addr_q;
        err_align_d = err_align_q;
        if (|accept) begin
            din_d  = bus_io.host_din[DATA_W-1:0];
            addr_d = bus_io.host_addra[ADDR_W+1:2];
        end
        if (start_acc) begin
            err_align_d = '0;
        end else if (wr_req && ch_ok && !aligned) begin
            err_align_d = err_align_q | ch_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            din_q       <= '0;
            addr_q      <= '0;
            ena_q       <= '0;
            err_align_q <= '0;
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            addr_q      <= addr_d;
            ena_q       <= ena_d;
            err_align_q <= err_align_d;
        end
    end

    assign bus_io.bram_din   = din_q;
    assign bus_io.bram_addra = addr_q;
    assign bus_io.bram_ena   = ena_q;
    assign bus_io.bram_wea   = ena_q;

    assign err_align = err_align_q;
    assign all_done  = (state_q == StDone);
    assign state_o   = state_q;

endmodule

// File: tb/tb_gat_bram_loader.sv
// Directed self-checking bench for gat_bram_loader. Inputs change on the
// falling edge; outputs are sampled on the falling edge after the rising edge.
module tb_gat_bram_loader;

    localparam int unsigned TOP_WIDTH = 32;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned DATA_W    = 19;
    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned LEN_W     = ADDR_W + 1;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      load_start;
    logic                      load_abort;
    logic [NUM_CH*LEN_W-1:0]   cfg_len;
    logic [NUM_CH-1:0]         load_done;
    logic                      all_done;
    logic [NUM_CH-1:0]         err_align;
    logic [NUM_CH-1:0]         err_ovf;
    logic [1:0]                state_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gat_bram_loader_if #(
        .TOP_WIDTH (TOP_WIDTH),
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W)
    ) bus ();

    gat_bram_loader #(
        .TOP_WIDTH (TOP_WIDTH),
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_abort (load_abort),
        .cfg_len    (cfg_len),
        .bus_io     (bus),
        .load_done  (load_done),
        .all_done   (all_done),
        .err_align  (err_align),
        .err_ovf    (err_ovf),
        .state_o    (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_wr(input int ch, input logic [19:0] addr, input logic [31:0] din);
        bus.host_ch    = 2'(ch);
        bus.host_addra = addr;
        bus.host_din   = din;
        bus.host_ena   = 1'b1;
        bus.host_wea   = 1'b1;
    endtask

    task automatic bus_idle();
        bus.host_ena = 1'b0;
        bus.host_wea = 1'b0;
    endtask

    function automatic logic [NUM_CH*LEN_W-1:0] pack_len(input int l0, input int l1,
                                                         input int l2, input int l3);
        return {LEN_W'(l3), LEN_W'(l2), LEN_W'(l1), LEN_W'(l0)};
    endfunction

    // Session 1 write table and the load_done value expected after each write.
    int          w_ch   [6] = '{0, 0, 0, 1, 1, 2};
    logic [19:0] w_addr [6] = '{20'h000, 20'h004, 20'h008, 20'h100, 20'h104, 20'h200};
    logic [31:0] w_din  [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    logic [3:0]  w_done [6] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1011, 4'b1111};

    initial begin
        rst_n          = 1'b0;
        load_start     = 1'b0;
        load_abort     = 1'b0;
        cfg_len        = '0;
        bus.host_ch    = '0;
        bus.host_din   = '0;
        bus.host_addra = '0;
        bus_idle();

        tick();
        tick();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ena", 32'(bus.bram_ena), 32'd0);
        check("rst_wea", 32'(bus.bram_wea), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_all_done", 32'(all_done), 32'd0);
        check("rst_din", 32'(bus.bram_din), 32'd0);
        check("rst_addra", 32'(bus.bram_addra), 32'd0);
        check("rst_err", 32'({err_align, err_ovf}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Session 1: lengths {3,2,1,0}, six back-to-back writes.
        cfg_len    = pack_len(3, 2, 1, 0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("s1_state_load", 32'(state_o), 32'd1);
        check("s1_zero_len_done", 32'(load_done), 32'b1000);
        for (int i = 0; i < 6; i++) begin
            drive_wr(w_ch[i], w_addr[i], w_din[i]);
            tick();
            check("s1_ena", 32'(bus.bram_ena), 32'd1 << w_ch[i]);
            check("s1_wea", 32'(bus.bram_wea), 32'd1 << w_ch[i]);
            check("s1_din", 32'(bus.bram_din), w_din[i]);
            check("s1_addra", 32'(bus.bram_addra), 32'(w_addr[i] >> 2));
            check("s1_done", 32'(load_done), 32'(w_done[i]));
        end
        bus_idle();
        check("s1_all_done_early", 32'(all_done), 32'd0);
        tick();
        check("s1_all_done", 32'(all_done), 32'd1);
        check("s1_state_done", 32'(state_o), 32'd2);
        check("s1_ena_idle", 32'(bus.bram_ena), 32'd0);

        // Session 2: alignment, ignored start, truncation, overflow, read enable.
        cfg_len    = pack_len(2, 1, 1, 1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("s2_state_load", 32'(state_o), 32'd1);
        check("s2_done_clr", 32'(load_done), 32'd0);

        drive_wr(1, 20'h00006, 32'hABC);
        tick();
        bus_idle();
        check("align_no_strobe", 32'(bus.bram_ena), 32'd0);
        check("align_err", 32'(err_align), 32'b0010);
        check("align_no_count", 32'(load_done), 32'd0);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("start_in_load_err", 32'(err_align), 32'b0010);
        check("start_in_load_state", 32'(state_o), 32'd1);

        drive_wr(1, 20'h00008, 32'h123);
        tick();
        check("ch1_ena", 32'(bus.bram_ena), 32'b0010);
        check("ch1_done", 32'(load_done), 32'b0010);
        check("ch1_addra", 32'(bus.bram_addra), 32'd2);

        drive_wr(0, 20'h00010, 32'hFFFF_FFFF);
        tick();
        check("trunc_din", 32'(bus.bram_din), 32'h7FFFF);
        check("trunc_addra", 32'(bus.bram_addra), 32'd4);
        check("trunc_ena", 32'(bus.bram_ena), 32'b0001);

        drive_wr(0, 20'h00014, 32'h5);
        tick();
        check("ch0_last_ena", 32'(bus.bram_ena), 32'b0001);
        check("ch0_done", 32'(load_done), 32'b0011);

        drive_wr(0, 20'h00018, 32'h77);
        tick();
        bus_idle();
        check("ovf_no_strobe", 32'(bus.bram_ena), 32'd0);
        check("ovf_err", 32'(err_ovf), 32'b0001);
        check("ovf_din_hold", 32'(bus.bram_din), 32'h5);
        check("ovf_addra_hold", 32'(bus.bram_addra), 32'd5);

        bus.host_ch  = 2'd2;
        bus.host_ena = 1'b1;
        bus.host_wea = 1'b0;
        tick();
        bus_idle();
        check("ena_only_strobe", 32'(bus.bram_ena), 32'd0);
        check("ena_only_done", 32'(load_done), 32'b0011);

        // Abort and start together: abort wins, errors survive.
        load_abort = 1'b1;
        load_start = 1'b1;
        tick();
        load_abort = 1'b0;
        load_start = 1'b0;
        check("abort_state", 32'(state_o), 32'd0);
        check("abort_done", 32'(load_done), 32'd0);
        check("abort_all_done", 32'(all_done), 32'd0);
        check("abort_err_ovf", 32'(err_ovf), 32'b0001);
        check("abort_err_align", 32'(err_align), 32'b0010);

        drive_wr(2, 20'h00020, 32'h9);
        tick();
        bus_idle();
        check("idle_wr_strobe", 32'(bus.bram_ena), 32'd0);
        check("idle_wr_done", 32'(load_done), 32'd0);

        // Session 3: reset in the middle of a load.
        cfg_len    = pack_len(2, 2, 2, 2);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("s3_err_clr", 32'({err_align, err_ovf}), 32'd0);
        drive_wr(0, 20'h00000, 32'h1);
        tick();
        check("s3_ena", 32'(bus.bram_ena), 32'b0001);
        drive_wr(0, 20'h00004, 32'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ena", 32'(bus.bram_ena), 32'd0);
        check("mid_rst_state", 32'(state_o), 32'd0);
        check("mid_rst_din", 32'(bus.bram_din), 32'd0);
        check("mid_rst_addra", 32'(bus.bram_addra), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_no_strobe", 32'(bus.bram_ena), 32'd0);
        check("post_rst_state", 32'(state_o), 32'd0);
        bus_idle();

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        drive_wr(0, 20'h0000C, 32'h3);
        tick();
        check("s4_ena", 32'(bus.bram_ena), 32'b0001);
        check("s4_din", 32'(bus.bram_din), 32'h3);
        drive_wr(0, 20'h00010, 32'h4);
        tick();
        bus_idle();
        check("s4_done", 32'(load_done), 32'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
